// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Optional timeout logic in the top is enabled by defining MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_BUSY} arb_state_e;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = 4;

  localparam logic [DataW-1:0] MEM_ARB_ERR_DATA = 32'hDEAD_BEEF;

  // Keeps ID vectors at least one bit wide even for degenerate N.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, with wrap-around.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IdW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] ptr,
  output logic [IdW-1:0] gnt_id,
  output logic           gnt_any
);

  localparam logic [IdW:0] NumW = (IdW+1)'(N);

  logic [IdW:0] idx;

  // Walk the rotated request vector; the first hit maps straight back to an absolute index.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + (IdW+1)'(i);
      if (idx >= NumW) begin
        idx = idx - NumW;
      end
      if (!gnt_any && req[idx[IdW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[IdW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory slave port among NUM_REQ masters, one transfer at a time.
// Define MEM_ARB_TIMEOUT_EN to add a per-transfer timeout with a sticky error flag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned TIMEOUT_CYC = 256,
  localparam int unsigned IdW = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   m_mem_valid,
  input  logic [NUM_REQ-1:0]   m_mem_write_en,
  input  logic [AddrW-1:0]     m_mem_addr    [NUM_REQ],
  input  logic [DataW-1:0]     m_mem_wdata   [NUM_REQ],
  input  logic [BeW-1:0]       m_mem_byte_en [NUM_REQ],
  output logic [NUM_REQ-1:0]   m_mem_ready,
  output logic [DataW-1:0]     m_mem_rdata   [NUM_REQ],
  output logic                 s_mem_valid,
  output logic                 s_mem_write_en,
  output logic [AddrW-1:0]     s_mem_addr,
  output logic [DataW-1:0]     s_mem_wdata,
  output logic [BeW-1:0]       s_mem_byte_en,
  input  logic                 s_mem_ready,
  input  logic [DataW-1:0]     s_mem_rdata,
  output logic [IdW-1:0]       grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam logic [IdW-1:0] LastId = IdW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("mem_port_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYC >= 1");
  end

  arb_state_e     state_q, state_d;
  logic [IdW-1:0] grant_q, grant_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] arb_id;
  logic           arb_any;
  logic           tmo_fire;
  logic           done;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr (
    .req    (m_mem_valid),
    .ptr    (ptr_q),
    .gnt_id (arb_id),
    .gnt_any(arb_any)
  );

  assign busy        = (state_q == ARB_BUSY);
  assign grant_id    = grant_q;
  assign s_mem_valid = busy;
  assign done        = busy & (s_mem_ready | tmo_fire);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q;
  logic            err_q;

  // A ready in the final cycle wins over the timeout.
  assign tmo_fire    = busy & ~s_mem_ready & (cnt_q == CntLast);
  assign timeout_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (!busy) begin
        cnt_q <= '0;
      end else if (!s_mem_ready) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (tmo_fire) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (arb_any) begin
          grant_d = arb_id;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (done) begin
          ptr_d   = (grant_q == LastId) ? '0 : grant_q + IdW'(1);
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  // Downstream fields read as zero whenever no transfer is in flight.
  always_comb begin
    s_mem_write_en = 1'b0;
    s_mem_addr     = '0;
    s_mem_wdata    = '0;
    s_mem_byte_en  = '0;
    if (busy) begin
      s_mem_write_en = m_mem_write_en[grant_q];
      s_mem_addr     = m_mem_addr[grant_q];
      s_mem_wdata    = m_mem_wdata[grant_q];
      s_mem_byte_en  = m_mem_byte_en[grant_q];
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      m_mem_ready[i] = 1'b0;
      m_mem_rdata[i] = '0;
      if (done && grant_q == IdW'(i)) begin
        m_mem_ready[i] = 1'b1;
        m_mem_rdata[i] = s_mem_ready ? s_mem_rdata : MEM_ARB_ERR_DATA;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner cases, random vs model.
// Timeout checks run only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  localparam int N   = 2;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_valid, m_we, m_ready;
  logic [31:0] m_addr [N];
  logic [31:0] m_wdata [N];
  logic [3:0]  m_be [N];
  logic [31:0] m_rdata [N];
  logic        s_valid, s_we, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_be;
  logic [0:0]  grant_id;
  logic        busy, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_REQ    (N),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .m_mem_valid   (m_valid),
    .m_mem_write_en(m_we),
    .m_mem_addr    (m_addr),
    .m_mem_wdata   (m_wdata),
    .m_mem_byte_en (m_be),
    .m_mem_ready   (m_ready),
    .m_mem_rdata   (m_rdata),
    .s_mem_valid   (s_valid),
    .s_mem_write_en(s_we),
    .s_mem_addr    (s_addr),
    .s_mem_wdata   (s_wdata),
    .s_mem_byte_en (s_be),
    .s_mem_ready   (s_ready),
    .s_mem_rdata   (s_rdata),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  // A master must hold valid until it has seen ready.
  logic [1:0] hold = 2'b00;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst && hold[i]) begin
        assert (m_valid[i])
        else begin
          $display("FAIL valid_hold m%0d: valid=0 required=1", i);
          errors++;
        end
      end
      hold[i] <= !rst && m_valid[i] && !m_ready[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    m_valid = 2'b00;
    s_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_fixed_masters();
    m_we[0] = 1'b0; m_addr[0] = 32'h100; m_wdata[0] = 32'h0;         m_be[0] = 4'hF;
    m_we[1] = 1'b1; m_addr[1] = 32'h200; m_wdata[1] = 32'hA5A5_0F0F; m_be[1] = 4'b0011;
  endtask

  typedef struct {
    logic [1:0] v;
    logic       rdy;
    logic       exp_busy;
    logic       exp_gid;
    logic [1:0] exp_ready;
  } vec_t;

  vec_t tbl [10];

  // Random-phase reference model: who owns the port, where the rotation resumes, stall count.
  bit          mb;
  int          mo, mp, mcnt;
  bit          merr;
  bit          pend [N];
  int          age [N];
  int          comp [N];
  int          max_age;

  initial begin
    logic [31:0] ea;
    logic [31:0] erd;
    bit          tmo, dn, found;
    int          cnt [N];

    rst = 1'b1; m_valid = 2'b00; m_we = 2'b00; s_ready = 1'b0; s_rdata = 32'h0;
    for (int i = 0; i < N; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_be[i] = '0;
    end
    @(negedge clk);
    tick();
    #1;
    check("rst_busy", busy, 0);
    check("rst_s_valid", s_valid, 0);
    check("rst_ready", m_ready, 0);
    check("rst_grant", grant_id, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_we", s_we, 0);
    check("rst_tmo_err", timeout_err, 0);
    rst = 1'b0;

    // Cycle-by-cycle vector table starting from reset (rotation pointer at 0).
    set_fixed_masters();
    tbl[0] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[1] = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[2] = '{2'b01, 1'b1, 1'b1, 1'b0, 2'b01};
    tbl[3] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[4] = '{2'b11, 1'b0, 1'b0, 1'b0, 2'b00};
    tbl[5] = '{2'b11, 1'b0, 1'b1, 1'b1, 2'b00};
    tbl[6] = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b10};
    tbl[7] = '{2'b01, 1'b1, 1'b0, 1'b0, 2'b00};
    tbl[8] = '{2'b01, 1'b1, 1'b1, 1'b0, 2'b01};
    tbl[9] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00};
    for (int k = 0; k < 10; k++) begin
      m_valid = tbl[k].v;
      s_ready = tbl[k].rdy;
      s_rdata = 32'h1234_5678;
      #1;
      check($sformatf("tbl%0d_busy", k), busy, tbl[k].exp_busy);
      check($sformatf("tbl%0d_s_valid", k), s_valid, tbl[k].exp_busy);
      check($sformatf("tbl%0d_ready", k), m_ready, tbl[k].exp_ready);
      check($sformatf("tbl%0d_rdata0", k), m_rdata[0], tbl[k].exp_ready[0] ? 32'h1234_5678 : 0);
      check($sformatf("tbl%0d_rdata1", k), m_rdata[1], tbl[k].exp_ready[1] ? 32'h1234_5678 : 0);
      if (tbl[k].exp_busy) begin
        check($sformatf("tbl%0d_gid", k), grant_id, tbl[k].exp_gid);
        check($sformatf("tbl%0d_we", k), s_we, tbl[k].exp_gid);
        check($sformatf("tbl%0d_addr", k), s_addr, tbl[k].exp_gid ? 32'h200 : 32'h100);
        check($sformatf("tbl%0d_wdata", k), s_wdata, tbl[k].exp_gid ? 32'hA5A5_0F0F : 0);
        check($sformatf("tbl%0d_be", k), s_be, tbl[k].exp_gid ? 32'h3 : 32'hF);
      end else begin
        check($sformatf("tbl%0d_addr_idle", k), s_addr, 0);
      end
      tick();
    end

    // Contention and fairness: both held valid from reset, slave always ready.
    do_reset();
    m_valid = 2'b11; s_ready = 1'b1; s_rdata = 32'hCAFE_0001;
    cnt[0] = 0; cnt[1] = 0;
    for (int k = 0; k < 16; k++) begin
      #1;
      check($sformatf("fair%0d_busy", k), busy, k % 2);
      if (k % 2 == 1) begin
        check($sformatf("fair%0d_gid", k), grant_id, ((k - 1) / 2) % 2);
        check($sformatf("fair%0d_ready", k), m_ready, 2'b01 << (((k - 1) / 2) % 2));
        if (m_ready[0]) cnt[0]++;
        if (m_ready[1]) cnt[1]++;
      end
      tick();
    end
    check("fair_count_m0", cnt[0], 4);
    check("fair_count_m1", cnt[1], 4);

    // Reset mid-transfer: park the pointer at 1, stall m1, reset, then contend again.
    do_reset();
    m_valid = 2'b01; s_ready = 1'b1;
    tick();
    #1 check("rmid_m0_ready", m_ready, 2'b01);
    tick();
    m_valid = 2'b10; s_ready = 1'b0;
    tick();
    #1 check("rmid_busy_m1", busy, 1);
    check("rmid_gid_m1", grant_id, 1);
    tick();
    rst = 1'b1; m_valid = 2'b00;
    tick();
    #1;
    check("rmid_s_valid", s_valid, 0);
    check("rmid_busy", busy, 0);
    check("rmid_ready", m_ready, 0);
    rst = 1'b0; m_valid = 2'b11; s_ready = 1'b1;
    tick();
    #1 check("rmid_rearb_gid", grant_id, 0);
    check("rmid_rearb_ready", m_ready, 2'b01);

`ifdef MEM_ARB_TIMEOUT_EN
    // Slave never answers: error completion on the last BUSY cycle.
    do_reset();
    m_valid = 2'b01; s_ready = 1'b0;
    tick();
    for (int k = 1; k <= TMO; k++) begin
      #1;
      check($sformatf("tmo_busy%0d", k), busy, 1);
      check($sformatf("tmo_ready%0d", k), m_ready, (k == TMO) ? 2'b01 : 2'b00);
      if (k == TMO) check("tmo_rdata", m_rdata[0], 32'hDEAD_BEEF);
      tick();
    end
    m_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("tmo_err_sticky%0d", k), timeout_err, 1);
      check($sformatf("tmo_idle%0d", k), busy, 0);
      tick();
    end
`endif

    // Random traffic against the rule-level model.
    do_reset();
    mb = 0; mo = 0; mp = 0; mcnt = 0; merr = 0; max_age = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; age[i] = 0; comp[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i]    = 1;
          age[i]     = 0;
          m_we[i]    = 1'($urandom_range(1));
          m_addr[i]  = $urandom;
          m_wdata[i] = $urandom;
          m_be[i]    = 4'($urandom_range(15));
        end
        m_valid[i] = pend[i];
      end
      s_ready = 1'($urandom_range(1));
      s_rdata = $urandom;
      #1;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo = mb && !s_ready && (mcnt == TMO - 1);
`else
      tmo = 0;
`endif
      dn = mb && (s_ready || tmo);
      check("rnd_busy", busy, mb);
      check("rnd_s_valid", s_valid, mb);
      check("rnd_tmo_err", timeout_err, merr);
      if (mb) begin
        check("rnd_gid", grant_id, mo);
        check("rnd_addr", s_addr, m_addr[mo]);
        check("rnd_wdata", s_wdata, m_wdata[mo]);
        check("rnd_we", s_we, m_we[mo]);
        check("rnd_be", s_be, m_be[mo]);
      end else begin
        check("rnd_addr_idle", s_addr, 0);
      end
      for (int i = 0; i < N; i++) begin
        erd = (dn && mo == i) ? (s_ready ? s_rdata : 32'hDEAD_BEEF) : 32'h0;
        check($sformatf("rnd_ready%0d", i), m_ready[i], dn && mo == i);
        check($sformatf("rnd_rdata%0d", i), m_rdata[i], erd);
      end
      if (!mb) begin
        found = 0;
        for (int j = 0; j < N; j++) begin
          if (!found && pend[(mp + j) % N]) begin
            found = 1;
            mo    = (mp + j) % N;
          end
        end
        if (found) begin
          mb = 1; mcnt = 0;
        end
      end else if (dn) begin
        mb = 0;
        mp = (mo + 1) % N;
        pend[mo] = 0;
        comp[mo]++;
        if (tmo) merr = 1;
      end else begin
        mcnt++;
      end
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          age[i]++;
          if (age[i] > max_age) max_age = age[i];
        end
      end
      tick();
    end
    check("rnd_no_starve", max_age < 200, 1);
    check("rnd_m0_served", comp[0] > 0, 1);
    check("rnd_m1_served", comp[1] > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
